// File: rtl/quad_steer_decoder_if.sv
// quad_steer_decoder_if: groups the sample enable, quadrature inputs, read
// strobe and all decoder outputs into one bundle. The master side (the
// environment) drives ce/quad_a/quad_b/rd. The slave side (the decoder)
// returns the position, delta, direction and pulse outputs.
interface quad_steer_decoder_if #(
  parameter int CNT_W = 8
);
  logic              ce;
  logic              quad_a;
  logic              quad_b;
  logic              rd;
  logic [CNT_W-1:0]  position;
  logic signed [7:0] delta;
  logic              dir;
  logic              step;
  logic              err;
  logic [3:0]        err_cnt;

  modport master (
    output ce, quad_a, quad_b, rd,
    input  position, delta, dir, step, err, err_cnt
  );

  modport slave (
    input  ce, quad_a, quad_b, rd,
    output position, delta, dir, step, err, err_cnt
  );
endinterface

// File: rtl/quad_steer_decoder.sv
// quad_steer_decoder: quadrature decoder for a steering encoder.
// The quadrature phases are synchronized with two flops, advanced on ce.
// They can optionally pass through a per-phase stability filter, which is
// enabled by defining the macro QUAD_FILTER_EN. The filtered {A,B} pair is
// then compared against its previous value on every ce cycle.
// Legal single-bit moves step the wrap-around position and the saturating
// delta. A move where both bits change is flagged on err and counted in err_cnt.
// Without QUAD_FILTER_EN the synchronizer output feeds the decoder directly,
// and FILT_LEN is only range-checked.
module quad_steer_decoder #(
  parameter int FILT_LEN = 4,
  parameter int CNT_W    = 8
) (
  input logic                 CLK,
  input logic                 Reset_n,
  quad_steer_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    MOVE_NONE = 2'd0,
    MOVE_CW   = 2'd1,
    MOVE_CCW  = 2'd2,
    MOVE_ERR  = 2'd3
  } move_t;

  // Map a Gray-coded {A,B} pair onto its position in the clockwise cycle
  // 00 -> 01 -> 11 -> 10, so that a move becomes a modulo-4 difference.
  function automatic logic [1:0] gray_to_phase(input logic [1:0] ab);
    logic [1:0] ph;
    case (ab)
      2'b00:   ph = 2'd0;
      2'b01:   ph = 2'd1;
      2'b11:   ph = 2'd2;
      2'b10:   ph = 2'd3;
      default: ph = 2'd0;
    endcase
    return ph;
  endfunction

  // Classify a transition: +1 phase is clockwise, -1 is counter-clockwise,
  // +2 means both bits flipped at once and the true direction is unknown.
  function automatic move_t classify_move(input logic [1:0] prev_ab,
                                          input logic [1:0] cur_ab);
    logic [1:0] diff;
    move_t      mv;
    diff = gray_to_phase(cur_ab) - gray_to_phase(prev_ab);
    case (diff)
      2'd0:    mv = MOVE_NONE;
      2'd1:    mv = MOVE_CW;
      2'd2:    mv = MOVE_ERR;
      2'd3:    mv = MOVE_CCW;
      default: mv = MOVE_NONE;
    endcase
    return mv;
  endfunction

  // The stability counter is 4 bits wide, so the hold length must fit.
  if (FILT_LEN < 1 || FILT_LEN > 15) begin : g_filt_len_check
    $error("quad_steer_decoder: FILT_LEN must lie in 1..15");
  end

  logic              sync_a1_r;
  logic              sync_a2_r;
  logic              sync_b1_r;
  logic              sync_b2_r;
  logic [1:0]        cur_pair_s;
  logic [1:0]        prev_pair_r;
  move_t             move_s;
  logic [CNT_W-1:0]  position_r;
  logic signed [7:0] delta_r;
  logic              dir_r;
  logic              step_r;
  logic              err_r;
  logic [3:0]        err_cnt_r;

  // Two-flop synchronizers for the asynchronous phase inputs, advanced on ce.
  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      sync_a1_r <= 1'b0;
      sync_a2_r <= 1'b0;
      sync_b1_r <= 1'b0;
      sync_b2_r <= 1'b0;
    end else if (bus.ce) begin
      sync_a1_r <= bus.quad_a;
      sync_a2_r <= sync_a1_r;
      sync_b1_r <= bus.quad_b;
      sync_b2_r <= sync_b1_r;
    end else begin
      sync_a1_r <= sync_a1_r;
      sync_a2_r <= sync_a2_r;
      sync_b1_r <= sync_b1_r;
      sync_b2_r <= sync_b2_r;
    end
  end

`ifdef QUAD_FILTER_EN
  // Accept a new level on the FILT_LEN-th consecutive differing sample,
  // which is the moment the counter already holds FILT_LEN-1.
  localparam logic [3:0] FILT_LAST = 4'(FILT_LEN - 1);

  logic [3:0] stab_a_r;
  logic [3:0] stab_b_r;
  logic       filt_a_r;
  logic       filt_b_r;

  // Per-phase stability filter: count differing ce samples and clear the
  // count as soon as the synchronized level returns to the filtered level.
  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      stab_a_r <= 4'd0;
      stab_b_r <= 4'd0;
      filt_a_r <= 1'b0;
      filt_b_r <= 1'b0;
    end else if (bus.ce) begin
      if (sync_a2_r != filt_a_r) begin
        if (stab_a_r == FILT_LAST) begin
          filt_a_r <= sync_a2_r;
          stab_a_r <= 4'd0;
        end else begin
          stab_a_r <= stab_a_r + 4'd1;
        end
      end else begin
        stab_a_r <= 4'd0;
      end
      if (sync_b2_r != filt_b_r) begin
        if (stab_b_r == FILT_LAST) begin
          filt_b_r <= sync_b2_r;
          stab_b_r <= 4'd0;
        end else begin
          stab_b_r <= stab_b_r + 4'd1;
        end
      end else begin
        stab_b_r <= 4'd0;
      end
    end else begin
      stab_a_r <= stab_a_r;
      stab_b_r <= stab_b_r;
      filt_a_r <= filt_a_r;
      filt_b_r <= filt_b_r;
    end
  end

  assign cur_pair_s = {filt_a_r, filt_b_r};
`else
  assign cur_pair_s = {sync_a2_r, sync_b2_r};
`endif

  // Classify the move between the last decoded pair and the current pair.
  always_comb begin
    move_s = classify_move(prev_pair_r, cur_pair_s);
  end

  // Decode stage: track the previous pair and update position, direction,
  // the one-cycle step/err pulses and the saturating error count.
  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      prev_pair_r <= 2'b00;
      position_r  <= '0;
      dir_r       <= 1'b0;
      step_r      <= 1'b0;
      err_r       <= 1'b0;
      err_cnt_r   <= 4'd0;
    end else if (bus.ce) begin
      prev_pair_r <= cur_pair_s;
      step_r      <= 1'b0;
      err_r       <= 1'b0;
      case (move_s)
        MOVE_CW: begin
          position_r <= position_r + CNT_W'(1);
          dir_r      <= 1'b1;
          step_r     <= 1'b1;
        end
        MOVE_CCW: begin
          position_r <= position_r - CNT_W'(1);
          dir_r      <= 1'b0;
          step_r     <= 1'b1;
        end
        MOVE_ERR: begin
          err_r <= 1'b1;
          if (err_cnt_r != 4'd15) begin
            err_cnt_r <= err_cnt_r + 4'd1;
          end else begin
            err_cnt_r <= err_cnt_r;
          end
        end
        default: begin
          position_r <= position_r;
        end
      endcase
    end else begin
      // Pulses last exactly one CLK cycle even when ce stays low afterwards.
      step_r <= 1'b0;
      err_r  <= 1'b0;
    end
  end

  // Signed step accumulator: rd clears it on any edge (ce not required),
  // and a step on the same edge as rd becomes the first count of the new window.
  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      delta_r <= 8'sd0;
    end else if (bus.rd) begin
      if (bus.ce && (move_s == MOVE_CW)) begin
        delta_r <= 8'sd1;
      end else if (bus.ce && (move_s == MOVE_CCW)) begin
        delta_r <= -8'sd1;
      end else begin
        delta_r <= 8'sd0;
      end
    end else if (bus.ce) begin
      if ((move_s == MOVE_CW) && (delta_r != 8'sh7F)) begin
        delta_r <= delta_r + 8'sd1;
      end else if ((move_s == MOVE_CCW) && (delta_r != -8'sd128)) begin
        delta_r <= delta_r - 8'sd1;
      end else begin
        delta_r <= delta_r;
      end
    end else begin
      delta_r <= delta_r;
    end
  end

  assign bus.position = position_r;
  assign bus.delta    = delta_r;
  assign bus.dir      = dir_r;
  assign bus.step     = step_r;
  assign bus.err      = err_r;
  assign bus.err_cnt  = err_cnt_r;

endmodule

// File: tb/tb_quad_steer_decoder.sv
// tb_quad_steer_decoder: directed vectors for quad_steer_decoder, with
// expected values computed by hand. The expected step latency follows
// QUAD_FILTER_EN (FILT_LEN+3 with the filter, 3 without it).
module tb_quad_steer_decoder;

  localparam int FILT_LEN = 4;
  localparam int CNT_W    = 8;
`ifdef QUAD_FILTER_EN
  localparam int LAT        = FILT_LEN + 3;
  localparam int GLITCH_STP = 0;
`else
  localparam int LAT        = 3;
  localparam int GLITCH_STP = 2;
`endif

  logic clk;
  logic rst_n;

  quad_steer_decoder_if #(.CNT_W(CNT_W)) bus ();

  quad_steer_decoder #(
    .FILT_LEN(FILT_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .CLK    (clk),
    .Reset_n(rst_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_vec;
  int         n_mis;
  int         step_seen;
  int         err_seen;
  int         excl_bad;
  int         first_lat;
  logic [1:0] cur_ab;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.step === 1'b1) step_seen++;
    if (bus.err === 1'b1) err_seen++;
    if (bus.step === 1'b1 && bus.err === 1'b1) excl_bad++;
  endtask

  // Apply an {A,B} level and hold it for n cycles, noting the first step.
  task automatic hold(input logic [1:0] ab, input int n);
    bus.quad_a = ab[1];
    bus.quad_b = ab[0];
    cur_ab     = ab;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (bus.step === 1'b1 && first_lat == 0) first_lat = i;
    end
  endtask

  function automatic logic [1:0] next_cw(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [31:0] u8(input logic [7:0] v);
    return {24'h0, v};
  endfunction

  task automatic chk_outs(input string tag, input logic [7:0] pos, input logic [7:0] dl,
                          input logic dr);
    chk({tag, "_pos"}, u8(bus.position), u8(pos));
    chk({tag, "_delta"}, u8($unsigned(bus.delta)), u8(dl));
    chk({tag, "_dir"}, {31'h0, bus.dir}, {31'h0, dr});
  endtask

  int s0;
  int e0;

  initial begin
    n_vec = 0; n_mis = 0; step_seen = 0; err_seen = 0; excl_bad = 0; first_lat = 0;
    cur_ab = 2'b00;
    rst_n = 1'b0; bus.ce = 1'b1; bus.quad_a = 1'b0; bus.quad_b = 1'b0; bus.rd = 1'b0;
    tick(); tick();
    // Reset state
    chk_outs("rst", 8'h00, 8'h00, 1'b0);
    chk("rst_step", {31'h0, bus.step}, 32'h0);
    chk("rst_err", {31'h0, bus.err}, 32'h0);
    chk("rst_errcnt", {28'h0, bus.err_cnt}, 32'h0);
    rst_n = 1'b1;
    hold(2'b00, 4);

    // Clockwise cycle, each level held 8 cycles
    s0 = step_seen; first_lat = 0;
    hold(2'b01, 8); hold(2'b11, 8); hold(2'b10, 8); hold(2'b00, 8);
    chk("cw_latency", 32'(first_lat), 32'(LAT));
    chk("cw_steps", 32'(step_seen - s0), 32'd4);
    chk_outs("cw", 8'h04, 8'h04, 1'b1);

    // rd with ce=1 and no step clears delta only
    bus.rd = 1'b1; tick(); bus.rd = 1'b0;
    chk_outs("rd_clr", 8'h04, 8'h00, 1'b1);

    // Counter-clockwise cycle, then one more CCW step that wraps below 0
    s0 = step_seen;
    hold(2'b10, 8); hold(2'b11, 8); hold(2'b01, 8); hold(2'b00, 8);
    chk("ccw_steps", 32'(step_seen - s0), 32'd4);
    chk_outs("ccw", 8'h00, 8'hFC, 1'b0);
    hold(2'b10, 8);
    chk_outs("wrap_dn", 8'hFF, 8'hFB, 1'b0);
    hold(2'b00, 8);
    chk_outs("wrap_up", 8'h00, 8'hFC, 1'b1);

    // Two-cycle glitch on phase A
    s0 = step_seen; e0 = err_seen;
    hold(2'b10, 2); hold(2'b00, 10);
    chk("glitch_steps", 32'(step_seen - s0), 32'(GLITCH_STP));
    chk("glitch_errs", 32'(err_seen - e0), 32'd0);
    chk_outs("glitch", 8'h00, 8'hFC, 1'b1);

    // Illegal 00->11 jump, then saturate the error count
    s0 = step_seen; e0 = err_seen;
    hold(2'b11, 8);
    chk("err_pulses1", 32'(err_seen - e0), 32'd1);
    chk("err_cnt1", {28'h0, bus.err_cnt}, 32'd1);
    chk_outs("err1", 8'h00, 8'hFC, 1'b1);
    hold(2'b00, 8);
    chk("err_cnt2", {28'h0, bus.err_cnt}, 32'd2);
    for (int k = 0; k < 9; k++) begin
      hold(2'b11, 8); hold(2'b00, 8);
    end
    chk("err_pulses20", 32'(err_seen - e0), 32'd20);
    chk("err_cnt_sat", {28'h0, bus.err_cnt}, 32'd15);
    chk("err_no_step", 32'(step_seen - s0), 32'd0);
    chk_outs("err_end", 8'h00, 8'hFC, 1'b1);

    // 130 clockwise steps saturate delta at +127
    bus.rd = 1'b1; tick(); bus.rd = 1'b0;
    s0 = step_seen;
    for (int k = 0; k < 130; k++) hold(next_cw(cur_ab), 8);
    chk("sat_steps", 32'(step_seen - s0), 32'd130);
    chk_outs("sat", 8'h82, 8'h7F, 1'b1);

    // rd on the same edge as a clockwise step reloads delta with +1
    s0 = step_seen;
    bus.quad_a = 1'b1; bus.quad_b = 1'b0; cur_ab = 2'b10;
    for (int k = 0; k < LAT - 1; k++) tick();
    chk("rdstep_pre", 32'(step_seen - s0), 32'd0);
    bus.rd = 1'b1; tick(); bus.rd = 1'b0;
    chk("rdstep_step", {31'h0, bus.step}, 32'd1);
    chk_outs("rdstep", 8'h83, 8'h01, 1'b1);
    for (int k = 0; k < 8 - LAT; k++) tick();
    chk("rdstep_hold", u8($unsigned(bus.delta)), 32'h01);

    // rd clears delta even with ce low
    bus.ce = 1'b0; bus.rd = 1'b1; tick(); bus.rd = 1'b0; bus.ce = 1'b1;
    chk_outs("rd_noce", 8'h83, 8'h00, 1'b1);

    // Three steps, then reset while a new level is still in flight
    s0 = step_seen;
    for (int k = 0; k < 3; k++) hold(next_cw(cur_ab), 8);
    chk_outs("pre_rst", 8'h86, 8'h03, 1'b1);
    hold(2'b10, 2);
    chk("mid_steps", 32'(step_seen - s0), 32'd3);
    rst_n = 1'b0; bus.quad_a = 1'b0; bus.quad_b = 1'b0; cur_ab = 2'b00;
    tick();
    chk_outs("mid_rst", 8'h00, 8'h00, 1'b0);
    chk("mid_rst_step", {31'h0, bus.step}, 32'h0);
    chk("mid_rst_err", {31'h0, bus.err}, 32'h0);
    chk("mid_rst_errcnt", {28'h0, bus.err_cnt}, 32'h0);
    rst_n = 1'b1;
    s0 = step_seen; e0 = err_seen;
    hold(2'b00, 8);
    chk("post_rst_idle", 32'(step_seen - s0 + err_seen - e0), 32'd0);
    hold(2'b01, 8);
    chk("post_rst_steps", 32'(step_seen - s0), 32'd1);
    chk_outs("post_rst", 8'h01, 8'h01, 1'b1);

    chk("step_err_excl", 32'(excl_bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
